// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between display fetch and host writes; FB_DBUF_EN adds a second page with frame-boundary swap.
// Latency: rgb_o/pix_valid_o follow the coordinates by 3 cycles; a buffered host write reaches the RAM 1 cycle after its first free slot.
// Backpressure: wr_ready_o drops only while the 1-entry buffer is full on a fetch slot, so at most 1 in 2^SCALE_SH cycles stalls.
module vga_fb_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_active_i,
  input  logic [10:0]       xcol_i,
  input  logic [10:0]       yrow_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
`ifdef FB_DBUF_EN
  output logic [ADDR_W:0]   ram_addr_o,
`else
  output logic [ADDR_W-1:0] ram_addr_o,
`endif
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] rgb_o,
  output logic              pix_valid_o,
  input  logic              swap_req_i,
  output logic              swap_done_o
);

`ifdef FB_DBUF_EN
  localparam int RA_W = ADDR_W + 1;
`else
  localparam int RA_W = ADDR_W;
`endif
  localparam int PIX_N = FB_W * FB_H;

  logic              fetch_slot;
  logic [31:0]       fetch_lin;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_fetch_hi;
  logic              wr_in_range;
  logic              wr_accept;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [RA_W-1:0]   fetch_ram_addr;
  logic [RA_W-1:0]   buf_ram_addr;
  logic              act_d1, fet_d1, act_d2, fet_d2;

  assign fetch_slot      = disp_active_i && (xcol_i[SCALE_SH-1:0] == '0);
  assign fetch_lin       = (({21'b0, yrow_i}) >> SCALE_SH) * 32'(FB_W) + (({21'b0, xcol_i}) >> SCALE_SH);
  assign fetch_addr      = fetch_lin[ADDR_W-1:0];
  assign unused_fetch_hi = |fetch_lin[31:ADDR_W];

  // Buffer can always take a new entry unless it is full and this slot belongs to the display.
  assign wr_ready_o  = !rst_i && (!buf_full || !fetch_slot);
  assign wr_accept   = wr_valid_i && wr_ready_o;
  assign wr_in_range = 32'(wr_addr_i) < 32'(PIX_N);

`ifdef FB_DBUF_EN
  logic front, swap_pend, buf_page, swap_boundary;

  assign fetch_ram_addr = {front, fetch_addr};
  assign buf_ram_addr   = {buf_page, buf_addr};
  assign swap_boundary  = (yrow_i == 11'd480) && (xcol_i == 11'd0);

  // A request landing on the boundary cycle itself re-arms swap_pend for the next frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      front       <= 1'b0;
      swap_pend   <= 1'b0;
      swap_done_o <= 1'b0;
      buf_page    <= 1'b0;
    end else begin
      swap_done_o <= 1'b0;
      if (swap_boundary && swap_pend) begin
        front       <= ~front;
        swap_done_o <= 1'b1;
        swap_pend   <= swap_req_i;
      end else if (swap_req_i) begin
        swap_pend <= 1'b1;
      end
      if (wr_accept && wr_in_range)
        buf_page <= ~front;
    end
  end
`else
  logic unused_swap_req;

  assign fetch_ram_addr  = fetch_addr;
  assign buf_ram_addr    = buf_addr;
  assign swap_done_o     = 1'b0;
  assign unused_swap_req = swap_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_full    <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      act_d1      <= 1'b0;
      fet_d1      <= 1'b0;
      act_d2      <= 1'b0;
      fet_d2      <= 1'b0;
      rgb_o       <= '0;
      pix_valid_o <= 1'b0;
    end else begin
      if (fetch_slot) begin
        ram_we_o   <= 1'b0;
        ram_addr_o <= fetch_ram_addr;
      end else if (buf_full) begin
        ram_we_o    <= 1'b1;
        ram_addr_o  <= buf_ram_addr;
        ram_wdata_o <= buf_data;
      end else begin
        ram_we_o <= 1'b0;
      end

      // Out-of-range writes complete the handshake but never occupy the buffer.
      if (wr_accept && wr_in_range) begin
        buf_full <= 1'b1;
        buf_addr <= wr_addr_i;
        buf_data <= wr_data_i;
      end else if (buf_full && !fetch_slot) begin
        buf_full <= 1'b0;
      end

      act_d1 <= disp_active_i;
      fet_d1 <= fetch_slot;
      act_d2 <= act_d1;
      fet_d2 <= fet_d1;
      if (act_d2) begin
        pix_valid_o <= 1'b1;
        if (fet_d2)
          rgb_o <= ram_rdata_i;
      end else begin
        pix_valid_o <= 1'b0;
        rgb_o       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: host writes are scoreboarded against RAM write cycles; pixel, fetch and swap outputs against cycle-stamped expectations.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
`ifdef FB_DBUF_EN
  localparam int RA_W = ADDR_W + 1;
  localparam bit DBUF = 1'b1;
`else
  localparam int RA_W = ADDR_W;
  localparam bit DBUF = 1'b0;
`endif
  localparam int K_RGB = 0, K_PV = 1, K_FETCH = 2, K_SWAP = 3;

  logic              clk, rst;
  logic              disp_active;
  logic [10:0]       xcol, yrow;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RA_W-1:0]   ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] rgb;
  logic              pix_valid;
  logic              swap_req, swap_done;

  vga_fb_arbiter dut (
    .clk_i(clk), .rst_i(rst), .disp_active_i(disp_active), .xcol_i(xcol), .yrow_i(yrow),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .rgb_o(rgb), .pix_valid_o(pix_valid), .swap_req_i(swap_req), .swap_done_o(swap_done)
  );

  logic [DATA_W-1:0] mem [0:(1<<RA_W)-1];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic exp_front = 1'b0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; int kind; logic [31:0] val; } tchk_t;
  wr_t   wr_q[$];
  tchk_t t_q[$];

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] wexp(input int a);
    if (DBUF) return 32'(a) | (32'(!exp_front) << ADDR_W);
    return 32'(a);
  endfunction

  task automatic expect_at(input int c, input int k, input logic [31:0] v);
    t_q.push_back('{c, k, v});
  endtask

  // Monitor: RAM writes pop the scoreboard; timed expectations fire on their cycle.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (ram_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write (cycle %0d)", ram_addr, ram_wdata, cyc);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(ram_addr), e.addr);
        chk("wr_data", 32'(ram_wdata), e.data);
      end
    end
    for (int i = t_q.size() - 1; i >= 0; i--) begin
      if (t_q[i].cyc == cyc) begin
        case (t_q[i].kind)
          K_RGB:   chk("rgb", 32'(rgb), t_q[i].val);
          K_PV:    chk("pix_valid", 32'(pix_valid), t_q[i].val);
          K_FETCH: begin
            chk("fetch_addr", 32'(ram_addr), t_q[i].val);
            chk("fetch_we", 32'(ram_we), 32'd0);
          end
          default: chk("swap_done", 32'(swap_done), t_q[i].val);
        endcase
        t_q.delete(i);
      end
    end
  end

  task automatic drive(input logic act, input int x, input int y, input logic wv, input int wa,
                       input logic [11:0] wd, input logic sreq, output logic rdy, output int c);
    disp_active = act; xcol = 11'(x); yrow = 11'(y);
    wr_valid = wv; wr_addr = 15'(wa); wr_data = wd; swap_req = sreq;
    c = cyc;
    @(negedge clk);
    rdy = wr_ready;
    if (wv && rdy && wa < 19200) wr_q.push_back('{wexp(wa), 32'(wd)});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic r; int c;
    for (int i = 0; i < n; i++) drive(1'b0, 700, 500, 1'b0, 0, 12'h0, 1'b0, r, c);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic rdy;
    int c, k;
    int xs[7];
    logic [11:0] pix[7];
    logic act4[7];
    xs = '{4, 5, 6, 7, 8, 9, 640};
    pix = '{12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'h5A5, 12'h5A5, 12'h000};
    act4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < (1 << RA_W); i++) mem[i] = '0;

    // T1 reset with a write pending on the port
    rst = 1'b1; disp_active = 1'b0; xcol = 11'd0; yrow = 11'd0;
    wr_valid = 1'b1; wr_addr = 15'd3; wr_data = 12'h123; swap_req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; wr_valid = 1'b0;
    idle(2);

    // T2 back-to-back writes in vertical blanking
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 700, 500, 1'b1, i, 12'(12'h100 + i), 1'b0, rdy, c);
      chk("t2_ready", 32'(rdy), 32'd1);
    end
    idle(3);

    // T3 active-region contention on row 0
    k = 0;
    for (int x = 0; x < 16; x++) begin
      drive(1'b1, x, 0, 1'b1, 100 + k, 12'(12'h200 + k), 1'b0, rdy, c);
      chk("t3_ready", 32'(rdy), (x != 0 && x % 4 == 0) ? 32'd0 : 32'd1);
      if (x % 4 == 0) expect_at(c + 1, K_FETCH, 32'(x / 4));
      if (rdy) k++;
    end
    chk("t3_accepts", 32'(k), 32'd13);
    idle(3);

    // T4 pixel pipeline
    mem[1] = 12'hABC;
    mem[2] = 12'h5A5;
    for (int i = 0; i < 7; i++) begin
      drive(act4[i], xs[i], 0, 1'b0, 0, 12'h0, 1'b0, rdy, c);
      expect_at(c + 3, K_RGB, 32'(pix[i]));
      expect_at(c + 3, K_PV, 32'(act4[i]));
      if (xs[i] == 4) expect_at(c + 1, K_FETCH, 32'd1);
      if (xs[i] == 8) expect_at(c + 1, K_FETCH, 32'd2);
    end
    drive(1'b1, 636, 476, 1'b0, 0, 12'h0, 1'b0, rdy, c);
    expect_at(c + 1, K_FETCH, 32'd19199);
    idle(4);

    // T5 out-of-range writes are accepted and dropped
    drive(1'b0, 700, 500, 1'b1, 19200, 12'hEEE, 1'b0, rdy, c);
    chk("t5_ready_19200", 32'(rdy), 32'd1);
    drive(1'b0, 700, 500, 1'b1, 32767, 12'hDDD, 1'b0, rdy, c);
    chk("t5_ready_32767", 32'(rdy), 32'd1);
    drive(1'b0, 700, 500, 1'b1, 19199, 12'h777, 1'b0, rdy, c);
    chk("t5_ready_19199", 32'(rdy), 32'd1);
    idle(3);

    // Reset between acceptance and drain aborts the write
    disp_active = 1'b0; xcol = 11'd700; yrow = 11'd500;
    wr_valid = 1'b1; wr_addr = 15'd50; wr_data = 12'h0F0;
    @(negedge clk);
    chk("abort_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_ready_in_rst", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_front = 1'b0;
    idle(3);

`ifdef FB_DBUF_EN
    // T6 page swap at the frame boundary; two requests merge into one swap
    drive(1'b0, 700, 100, 1'b0, 0, 12'h0, 1'b1, rdy, c);
    drive(1'b0, 700, 200, 1'b0, 0, 12'h0, 1'b1, rdy, c);
    drive(1'b0, 799, 479, 1'b0, 0, 12'h0, 1'b0, rdy, c);
    expect_at(c + 1, K_SWAP, 32'd0);
    drive(1'b0, 0, 480, 1'b0, 0, 12'h0, 1'b0, rdy, c);
    expect_at(c + 1, K_SWAP, 32'd1);
    drive(1'b0, 1, 480, 1'b0, 0, 12'h0, 1'b0, rdy, c);
    expect_at(c + 1, K_SWAP, 32'd0);
    exp_front = 1'b1;
    drive(1'b0, 700, 500, 1'b1, 5, 12'h3C3, 1'b0, rdy, c);
    chk("t6_ready", 32'(rdy), 32'd1);
    drive(1'b1, 8, 4, 1'b0, 0, 12'h0, 1'b0, rdy, c);
    expect_at(c + 1, K_FETCH, 32'd32930);
    idle(4);
`else
    // Single page: swap requests have no effect
    drive(1'b0, 0, 480, 1'b0, 0, 12'h0, 1'b1, rdy, c);
    expect_at(c + 1, K_SWAP, 32'd0);
    idle(2);
`endif

    chk("wr_scoreboard_empty", 32'(wr_q.size()), 32'd0);
    chk("timed_queue_empty", 32'(t_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
